// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM state
// codes, operand classes and format-dependent constants.
package fp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  // Exponent bias for an E-bit exponent field: 2^(E-1)-1.
  function automatic int unsigned fp_bias(input int unsigned e);
    return (32'd1 << (e - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN (sign 0, exponent all ones, fraction MSB set),
  // right-aligned in 64 bits; callers cast to their own width.
  function automatic logic [63:0] fp_qnan(input int unsigned e, input int unsigned m);
    logic [63:0] v;
    v = ((64'd1 << e) - 64'd1) << m;
    v = v | (64'd1 << (m - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier. Subnormals are reported as ZERO so the
// datapath never sees a denormal mantissa.
module fp_classify
  import fp_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic [E+M:0] x,
  output fp_class_t    cls
);

  logic [E-1:0] exp_f;
  logic [M-1:0] frac_f;

  assign exp_f  = x[E+M-1:M];
  assign frac_f = x[M-1:0];

  // Decode the exponent/fraction fields into a class.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == '1) begin
      cls = (frac_f == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754-format divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, truncating rounding, flush-to-zero. Special
// operands travel the same DIV/NORM path so latency never depends on data.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter  int E  = 8,
  parameter  int M  = 23,
  localparam int DW = 1 + E + M
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [3:0]    flags
);

  localparam int CW = $clog2(M + 3);
  localparam logic [DW-1:0]      QNAN = DW'(fp_qnan(E, M));
  localparam logic signed [E+1:0] BIAS = (E + 2)'(fp_bias(E));
  localparam logic signed [E+1:0] EMAX = (E + 2)'((1 << E) - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          sign;
  logic [E-1:0]  ea, eb;
  logic [M+1:0]  rem;
  logic [M:0]    dsr;
  logic [M+1:0]  q;
  fp_class_t     cls_a, cls_b, ca, cb;

  logic                 ge;
  logic [M+1:0]         rem_sel;
  logic signed [E+1:0]  exp_s;
  logic [M-1:0]         frac_n;
  logic [DW-1:0]        res_q;
  logic [3:0]           res_f;

  fp_classify #(.E(E), .M(M)) u_cls_a (.x(dividend), .cls(cls_a));
  fp_classify #(.E(E), .M(M)) u_cls_b (.x(divisor),  .cls(cls_b));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One restoring-division step: subtract when the partial remainder covers the divisor.
  always_comb begin
    ge      = (rem >= {1'b0, dsr});
    rem_sel = ge ? (rem - {1'b0, dsr}) : rem;
  end

  // Normalise the quotient, then let special classes override the numeric result.
  always_comb begin
    exp_s  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS
             - (q[M+1] ? (E + 2)'(0) : (E + 2)'(1));
    frac_n = q[M+1] ? q[M:1] : q[M-1:0];
    res_q  = {sign, exp_s[E-1:0], frac_n};
    res_f  = 4'b0000;
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
      res_q = QNAN;
      res_f = 4'b1000;
    end else if (ca == NORMAL && cb == ZERO) begin
      res_q = {sign, {E{1'b1}}, {M{1'b0}}};
      res_f = 4'b0100;
    end else if (ca == INF) begin
      res_q = {sign, {E{1'b1}}, {M{1'b0}}};
    end else if (cb == INF || ca == ZERO) begin
      res_q = {sign, {(E + M){1'b0}}};
    end else if (exp_s >= EMAX) begin
      res_q = {sign, {E{1'b1}}, {M{1'b0}}};
      res_f = 4'b0010;
    end else if (exp_s <= 0) begin
      res_q = {sign, {(E + M){1'b0}}};
      res_f = 4'b0001;
    end
  end

  // Control FSM and datapath registers.
  // DIV spends M+2 cycles producing quotient bits and one more seeing the
  // counter at zero, which gives the fixed M+4 edge latency to out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sign     <= 1'b0;
      ea       <= '0;
      eb       <= '0;
      rem      <= '0;
      dsr      <= '0;
      q        <= '0;
      ca       <= ZERO;
      cb       <= ZERO;
      quotient <= '0;
      flags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= DIV;
            cnt   <= CW'(M + 2);
            sign  <= dividend[DW-1] ^ divisor[DW-1];
            ea    <= dividend[DW-2:M];
            eb    <= divisor[DW-2:M];
            rem   <= {2'b01, dividend[M-1:0]};
            dsr   <= {1'b1, divisor[M-1:0]};
            q     <= '0;
            ca    <= cls_a;
            cb    <= cls_b;
          end
        end
        DIV: begin
          if (cnt == '0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - CW'(1);
            q   <= {q[M:0], ge};
            rem <= rem_sel << 1;
          end
        end
        NORM: begin
          quotient <= res_q;
          flags    <= res_f;
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed self-checking bench for fp_div_iter (single precision).
module tb_fp_div_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [3:0]  flags;

  int nchecks = 0;
  int nerrors = 0;

  fp_div_iter #(.E(8), .M(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, check latency and result, optionally stall the
  // consumer for 'hold' cycles while poking ignored operands.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [3:0] exp_f, input int hold);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd27);
    check({tag, "_q"}, {32'd0, quotient}, {32'd0, exp_q});
    check({tag, "_flags"}, {60'd0, flags}, {60'd0, exp_f});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      dividend = 32'h3F800000;
      divisor  = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_q"}, {32'd0, quotient}, {32'd0, exp_q});
      check({tag, "_hold_f"}, {60'd0, flags}, {60'd0, exp_f});
      check({tag, "_hold_ov"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_hold_ir"}, {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_consumed"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quotient", {32'd0, quotient}, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);

    run_op("div_8_4",   32'h41000000, 32'h40800000, 32'h40000000, 4'b0000, 0);
    run_op("div_1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 0);
    run_op("div_3_2",   32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 0);
    run_op("div_m6_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 0);
    run_op("div_1_0",   32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
    run_op("div_m1_0",  32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 0);
    run_op("div_0_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    run_op("div_nan",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
    run_op("div_inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
    run_op("div_inf_2", 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0);
    run_op("div_2_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 0);
    run_op("div_0_m2",  32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 0);
    run_op("div_sub_1", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0);
    run_op("div_1_sub", 32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0100, 0);
    run_op("div_ovf",   32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 0);
    run_op("div_unf",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0);
    run_op("div_hold",  32'h41000000, 32'h40800000, 32'h40000000, 4'b0000, 10);

    // Reset in the middle of DIV abandons the operation.
    @(negedge clk);
    dividend = 32'h41000000;
    divisor  = 32'h40800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ov", {63'd0, out_valid}, 64'd0);
    check("midrst_ir", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ir_rel", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    run_op("div_after_rst", 32'h41000000, 32'h40800000, 32'h40000000, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
